// File: rtl/seven_seg_scan.sv
// seven_seg_scan
// Time-multiplexed driver for a bank of NUM_DIGITS common-anode seven-segment
// digits that share one set of segment pins.
//
// Each digit owns a slot of SCAN_DIV clock cycles. The first cycle of every
// slot is a dead cycle with all anodes off, so the previous digit's pattern
// cannot ghost onto the next one.
//
// Displayed data lives in a shadow register that changes only at frame
// boundaries, so a frame never shows a mix of old and new values. Features
// layered on top of the basic decoder:
//   - leading-zero blanking;
//   - per-digit blink, with a half-period of BLINK_FRAMES frames;
//   - per-digit decimal points.
//
// Ports:
//   CLK         rising-edge system clock
//   RESET       asynchronous, active-high reset
//   DATA        hex nibbles; digit j = DATA[4j+3:4j], digit 0 least significant
//   DP_IN       decimal-point request per digit, captured together with DATA
//   LOAD        single-cycle strobe capturing DATA/DP_IN into the pending register
//   BLANK_LZ    leading-zero blanking enable (live level)
//   BLINK_MASK  digits to blink (live level)
//   DISABLE     forces the whole display dark (live level)
//   SEG         segments {g,f,e,d,c,b,a}, active-low, registered
//   DP          decimal point, active-low, registered
//   AN          digit anodes, active-low, registered, at most one low
module seven_seg_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1024,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [4*NUM_DIGITS-1:0] DATA,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    input  logic                    LOAD,
    input  logic                    BLANK_LZ,
    input  logic [NUM_DIGITS-1:0]   BLINK_MASK,
    input  logic                    DISABLE,
    output logic [6:0]              SEG,
    output logic                    DP,
    output logic [NUM_DIGITS-1:0]   AN
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PSC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

    // Scan and blink state
    logic [PW-1:0] psc;
    logic [IW-1:0] idx;
    logic [FW-1:0] fcnt;
    logic          phase;

    // Load path: pending captures LOAD, shadow feeds the display
    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_vld;
    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic slot_end;
    logic frame_end;

    // Current-digit selections
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blink;
    logic                  cur_lz;
    logic [NUM_DIGITS-1:0] an_sel;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zrun;

    // Next registered output values
    logic                  dark;
    logic                  blink_off;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign slot_end  = (psc == PSC_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // A digit is a leading zero when it and every higher digit are zero.
    // Digit 0 is excluded so that a value of zero still shows one "0".
    always_comb begin
        lz_mask = '0;
        zrun    = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
            zrun = zrun && (shadow_data[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
            lz_mask[NUM_DIGITS-1-k] = zrun && BLANK_LZ;
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        an_sel    = '1;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if (idx == IW'(j)) begin
                cur_nib   = shadow_data[4*j +: 4];
                cur_dp    = shadow_dp[j];
                cur_blink = BLINK_MASK[j];
                cur_lz    = lz_mask[j];
                an_sel[j] = 1'b0;
            end
        end
    end

    always_comb begin
        dark      = DISABLE || (psc == '0);
        blink_off = phase && cur_blink;
        an_nxt    = dark ? '1 : an_sel;
        seg_nxt   = (dark || blink_off || cur_lz) ? 7'h7F : hex7(cur_nib);
        // A leading-zero blanked digit still shows its decimal point
        dp_nxt    = (dark || blink_off) ? 1'b1 : ~cur_dp;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            psc         <= '0;
            idx         <= '0;
            fcnt        <= '0;
            phase       <= 1'b0;
            pend_data   <= '0;
            pend_dp     <= '0;
            pend_vld    <= 1'b0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            SEG         <= '1;
            DP          <= 1'b1;
            AN          <= '1;
        end else begin
            SEG <= seg_nxt;
            DP  <= dp_nxt;
            AN  <= an_nxt;

            if (slot_end) begin
                psc <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                psc <= psc + 1'b1;
            end

            if (frame_end) begin
                if (fcnt == FRM_LAST) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end

            // A LOAD landing on the transfer edge bypasses pending straight
            // into shadow, so nothing is left waiting for the next frame.
            if (frame_end) begin
                pend_vld <= 1'b0;
                if (LOAD) begin
                    pend_data   <= DATA;
                    pend_dp     <= DP_IN;
                    shadow_data <= DATA;
                    shadow_dp   <= DP_IN;
                end else if (pend_vld) begin
                    shadow_data <= pend_data;
                    shadow_dp   <= pend_dp;
                end
            end else if (LOAD) begin
                pend_data <= DATA;
                pend_dp   <= DP_IN;
                pend_vld  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan
// Directed bench for seven_seg_scan with NUM_DIGITS=4, SCAN_DIV=4 and
// BLINK_FRAMES=2.
//
// Frame length is 16 cycles. After reset release, output edge k shows
// counter state k-1, so frame f covers edges 16f+1..16f+16. Within a
// frame, edge offset e=1..16 gives slot position p=(e-1)%4 and digit
// d=(e-1)/4; p=0 is the dead cycle.
module tb_seven_seg_scan;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] DATA = '0;
    logic [3:0]  DP_IN = '0;
    logic        LOAD = 1'b0;
    logic        BLANK_LZ = 1'b0;
    logic [3:0]  BLINK_MASK = '0;
    logic        DISABLE = 1'b0;
    logic [6:0]  SEG;
    logic        DP;
    logic [3:0]  AN;

    seven_seg_scan #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .DATA       (DATA),
        .DP_IN      (DP_IN),
        .LOAD       (LOAD),
        .BLANK_LZ   (BLANK_LZ),
        .BLINK_MASK (BLINK_MASK),
        .DISABLE    (DISABLE),
        .SEG        (SEG),
        .DP         (DP),
        .AN         (AN)
    );

    always #5 CLK = ~CLK;

    // Edges since the last reset release
    int cyc;
    always @(posedge CLK or posedge RESET) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int nvec = 0;
    int nbad = 0;

    localparam logic [6:0]  Z    = 7'b1000000;
    localparam logic [6:0]  OFF  = 7'b1111111;
    localparam logic [11:0] DARK = {4'b1111, 7'b1111111, 1'b1};

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic        blz;
        logic [27:0] eseg;  // {d3,d2,d1,d0}
        logic [3:0]  edp;   // expected DP pin per digit, active-low
    } vec_t;

    vec_t tbl[7];

    task automatic goto(input int k);
        int guard = 0;
        while (cyc < k && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        if (cyc != k) begin
            nvec++;
            nbad++;
            $display("FAIL goto: reached edge %0d, needed edge %0d", cyc, k);
        end
    endtask

    task automatic cmp(input string name, input int k,
                       input logic [11:0] got, input logic [11:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s edge %0d: got AN=%b SEG=%b DP=%b, want AN=%b SEG=%b DP=%b",
                     name, k, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic cmp_bit(input string name, input logic got, input logic exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %b, want %b", name, got, exp);
        end
    endtask

    function automatic logic [11:0] exp_out(input int e, input logic [27:0] eseg,
                                            input logic [3:0] edp);
        int p;
        int d;
        logic [3:0] an;
        p  = (e - 1) % 4;
        d  = (e - 1) / 4;
        an = ~(4'b0001 << d);
        if (p == 0) return DARK;
        return {an, eseg[d*7 +: 7], edp[d]};
    endfunction

    task automatic check_frame(input string name, input int base,
                               input logic [27:0] eseg, input logic [3:0] edp);
        for (int e = 1; e <= 16; e++) begin
            goto(base + e);
            cmp(name, base + e, {AN, SEG, DP}, exp_out(e, eseg, edp));
        end
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] dp);
        DATA  = d;
        DP_IN = dp;
        LOAD  = 1'b1;
        @(negedge CLK);
        LOAD  = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        cmp("reset_hold", 0, {AN, SEG, DP}, DARK);
        RESET = 1'b0;
    endtask

    logic [27:0] s_12af;
    logic [27:0] s_zero;
    logic [27:0] s_c0de;
    logic [27:0] s5;
    logic [11:0] want;

    initial begin
        s_12af = {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110};
        s_zero = {Z, Z, Z, Z};
        s_c0de = {7'b1000110, Z, 7'b0100001, 7'b0000110};

        tbl[0] = '{16'h0070, 4'b0000, 1'b1, {OFF, OFF, 7'b1111000, Z}, 4'b1111};
        tbl[1] = '{16'h0000, 4'b0000, 1'b1, {OFF, OFF, OFF, Z}, 4'b1111};
        tbl[2] = '{16'h3456, 4'b0101, 1'b0,
                   {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}, 4'b1010};
        tbl[3] = '{16'h89BC, 4'b0000, 1'b1,
                   {7'b0000000, 7'b0010000, 7'b0000011, 7'b1000110}, 4'b1111};
        tbl[4] = '{16'h0DE0, 4'b1000, 1'b1, {OFF, 7'b0100001, 7'b0000110, Z}, 4'b0111};
        tbl[5] = '{16'h0007, 4'b0000, 1'b0, {Z, Z, Z, 7'b1111000}, 4'b1111};
        tbl[6] = '{16'h00A0, 4'b0100, 1'b1, {OFF, OFF, 7'b0001000, Z}, 4'b1011};

        // Reset state, then first load: frame 0 still shows the cleared shadow
        @(negedge CLK);
        do_reset();
        cmp("reset_state", 0, {AN, SEG, DP}, DARK);
        DATA  = 16'h12AF;
        DP_IN = 4'b0000;
        LOAD  = 1'b1;
        goto(1);
        LOAD  = 1'b0;
        check_frame("old_shadow", 0, s_zero, 4'b1111);
        check_frame("load_12af", 16, s_12af, 4'b1111);

        // Table: load mid-frame, check the next full frame
        for (int i = 0; i < 7; i++) begin
            int b;
            b = cyc;
            goto(b + 5);
            BLANK_LZ = tbl[i].blz;
            pulse_load(tbl[i].data, tbl[i].dp);
            check_frame("table", b + 16, tbl[i].eseg, tbl[i].edp);
        end
        BLANK_LZ = 1'b0;

        // Blink on digit 0: dark in frames 2-3, lit in 0-1 and 4-5
        @(negedge CLK);
        do_reset();
        BLINK_MASK = 4'b0001;
        DATA  = 16'h0005;
        DP_IN = 4'b0001;
        LOAD  = 1'b1;
        goto(1);
        LOAD  = 1'b0;
        s5 = {Z, Z, Z, 7'b0010010};
        check_frame("blink_f0", 0, s_zero, 4'b1111);
        check_frame("blink_f1", 16, s5, 4'b1110);
        check_frame("blink_f2", 32, {Z, Z, Z, OFF}, 4'b1111);
        check_frame("blink_f3", 48, {Z, Z, Z, OFF}, 4'b1111);
        check_frame("blink_f4", 64, s5, 4'b1110);
        check_frame("blink_f5", 80, s5, 4'b1110);
        BLINK_MASK = 4'b0000;

        // Frame 6: mid-frame LOAD, then LOAD coincident with the transfer edge 112
        for (int k = 97; k <= 112; k++) begin
            goto(k);
            cmp("no_tear", k, {AN, SEG, DP}, exp_out(k - 96, s5, 4'b1110));
            if (k == 101) begin
                DATA  = 16'h0ABC;
                DP_IN = 4'b0000;
                LOAD  = 1'b1;
            end
            if (k == 102) begin
                LOAD = 1'b0;
                cmp_bit("pend_set", dut.pend_vld, 1'b1);
            end
            if (k == 111) begin
                DATA  = 16'hC0DE;
                DP_IN = 4'b0010;
                LOAD  = 1'b1;
            end
            if (k == 112) begin
                LOAD = 1'b0;
                cmp_bit("pend_clear", dut.pend_vld, 1'b0);
            end
        end
        check_frame("boundary_load", 112, s_c0de, 4'b1101);

        // DISABLE for edges 131..140, then scanning continues in place
        for (int k = 129; k <= 160; k++) begin
            goto(k);
            if (k >= 131 && k <= 140) want = DARK;
            else                      want = exp_out(((k - 129) % 16) + 1, s_c0de, 4'b1101);
            cmp("disable", k, {AN, SEG, DP}, want);
            if (k == 130) DISABLE = 1'b1;
            if (k == 140) DISABLE = 1'b0;
        end

        // Asynchronous reset mid-slot: outputs go dark before any clock edge
        goto(166);
        cmp("pre_reset_lit", 166, {AN, SEG, DP}, exp_out(6, s_c0de, 4'b1101));
        #2 RESET = 1'b1;
        #1 cmp("async_reset", 166, {AN, SEG, DP}, DARK);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        cmp_bit("reset_pend", dut.pend_vld, 1'b0);
        check_frame("post_reset_f0", 0, s_zero, 4'b1111);
        check_frame("post_reset_f1", 16, s_zero, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d vectors, want completion", nvec);
        $fatal(1);
    end

endmodule
